// File: rtl/bcd_seq_splitter.sv
// Sequential binary-to-BCD splitter (double dabble), one bit per cycle.
// Registered digits, overflow saturation and leading-zero mask on a valid/ready pair.
module bcd_seq_splitter #(
  parameter int IN_W     = 10,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);
  localparam int unsigned MAXV = 10 ** DIGITS - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q;
  logic [IN_W-1:0] bin_q;
  logic [DW-1:0]   dig_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic            out_valid_q;
  logic [DW-1:0]   bcd_q;
  logic            overflow_q;
  logic [DIGITS-1:0] lz_q;

  logic [DW-1:0]     adj;
  logic [DW-1:0]     dig_d;
  logic [IN_W-1:0]   bin_d;
  logic [DIGITS-1:0] lz_d;
  logic              zrun;
  logic              accept;
  logic              in_ovf;

  assign in_ready = (state_q == IDLE)
                  | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign in_ovf   = 32'(bin_in) > MAXV;

  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign overflow  = overflow_q;
  assign lz_mask   = lz_q;

  always_comb begin
    adj = dig_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
    end
    dig_d = {adj[DW-2:0], bin_q[IN_W-1]};
    bin_d = bin_q << 1;
  end

  // Scan from the top digit down; a bit stays set while every digit above is zero.
  always_comb begin
    lz_d = '0;
    zrun = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zrun    = zrun & (dig_d[4*k +: 4] == 4'd0);
      lz_d[k] = zrun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      dig_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
      lz_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            bin_q   <= bin_in;
            dig_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= in_ovf;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          dig_q <= dig_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(IN_W - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            overflow_q  <= ovf_q;
            bcd_q       <= ovf_q ? {DIGITS{4'h9}} : dig_d;
            lz_q        <= (BLANK_LZ != 0 && !ovf_q) ? lz_d : '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            if (in_valid) begin
              bin_q   <= bin_in;
              dig_q   <= '0;
              cnt_q   <= '0;
              ovf_q   <= in_ovf;
              state_q <= SHIFT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_splitter.sv
// Bench for bcd_seq_splitter: three parameter sets against a decimal-arithmetic model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_bcd_seq_splitter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] iv, ordy, ir, ov, ovf;
  logic [9:0]  bin_a;
  logic [11:0] bcd_a;
  logic [2:0]  lz_a;
  logic [13:0] bin_b;
  logic [19:0] bcd_b;
  logic [4:0]  lz_b;
  logic [3:0]  bin_c;
  logic [3:0]  bcd_c;
  logic [0:0]  lz_c;

  int checks = 0;
  int failures = 0;

  bcd_seq_splitter #(.IN_W(10), .DIGITS(3), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .bin_in(bin_a),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .bcd_out(bcd_a), .overflow(ovf[0]), .lz_mask(lz_a)
  );

  bcd_seq_splitter #(.IN_W(14), .DIGITS(5), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .bin_in(bin_b),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .bcd_out(bcd_b), .overflow(ovf[1]), .lz_mask(lz_b)
  );

  bcd_seq_splitter #(.IN_W(4), .DIGITS(1), .BLANK_LZ(1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]), .bin_in(bin_c),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .bcd_out(bcd_c), .overflow(ovf[2]), .lz_mask(lz_c)
  );

  // Decimal digits by division; leading zero k means the value is below 10^k.
  function automatic void model(input int unsigned v, input int d,
                                output logic [23:0] bcd, output logic o,
                                output logic [5:0] lz);
    int unsigned x;
    bcd = '0;
    lz  = '0;
    o   = v > (10 ** d - 1);
    x   = v;
    for (int k = 0; k < d; k++) begin
      bcd[4*k +: 4] = o ? 4'd9 : 4'(x % 10);
      x = x / 10;
    end
    if (!o)
      for (int k = 1; k < d; k++) lz[k] = v < (10 ** k);
  endfunction

  task automatic run(input int sel, input int unsigned v,
                     output logic [23:0] bcd, output logic o,
                     output logic [5:0] lz, output int lat);
    @(negedge clk);
    case (sel)
      0: bin_a = 10'(v);
      1: bin_b = 14'(v);
      default: bin_c = 4'(v);
    endcase
    iv[sel]   = 1'b1;
    ordy[sel] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[sel] = 1'b0;
    lat = 0;
    while (!ov[sel] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!ov[sel]) lat = -1;
    case (sel)
      0: begin bcd = 24'(bcd_a); o = ovf[0]; lz = 6'(lz_a); end
      1: begin bcd = 24'(bcd_b); o = ovf[1]; lz = 6'(lz_b); end
      default: begin bcd = 24'(bcd_c); o = ovf[2]; lz = 6'(lz_c); end
    endcase
    ordy[sel] = 1'b1;
    @(negedge clk);
    ordy[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = '0; ordy = '0;
    bin_a = '0; bin_b = '0; bin_c = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (ov[0] !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid got=%b exp=0", ov[0]); end
    checks++;
    if (bcd_a !== 12'h000) begin failures++;
      $display("FAIL reset_bcd got=%h exp=000", bcd_a); end
    checks++;
    if (ovf[0] !== 1'b0 || lz_a !== 3'b000) begin failures++;
      $display("FAIL reset_ovf_lz got=%b/%b exp=0/000", ovf[0], lz_a); end
    checks++;
    if (ir !== 3'b111) begin failures++;
      $display("FAIL reset_in_ready got=%b exp=111", ir); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_conv(input int sel, input int d, input int w,
                            input int unsigned v, input bit chk_lat);
    logic [23:0] gb, eb;
    logic go, eo;
    logic [5:0] gl, el;
    int lat;
    run(sel, v, gb, go, gl, lat);
    model(v, d, eb, eo, el);
    checks++;
    if (gb !== eb) begin failures++;
      $display("FAIL conv%0d_bcd v=%0d got=%h exp=%h", sel, v, gb, eb); end
    checks++;
    if (go !== eo) begin failures++;
      $display("FAIL conv%0d_ovf v=%0d got=%b exp=%b", sel, v, go, eo); end
    checks++;
    if (gl !== el) begin failures++;
      $display("FAIL conv%0d_lz v=%0d got=%b exp=%b", sel, v, gl, el); end
    if (chk_lat) begin
      checks++;
      if (lat !== w) begin failures++;
        $display("FAIL conv%0d_latency v=%0d got=%0d exp=%0d", sel, v, lat, w); end
    end
  endtask

  task automatic test_directed();
    int unsigned vals[6] = '{0, 42, 507, 999, 1000, 1023};
    foreach (vals[i]) check_conv(0, 3, 10, vals[i], 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      check_conv(0, 3, 10, $urandom_range(1023, 0), 1'b0);
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    int n;
    @(negedge clk);
    bin_a = 10'd314; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (ov[0] !== 1'b1 || bcd_a !== 12'h314) begin failures++;
      $display("FAIL bp_result got=%b/%h exp=1/314", ov[0], bcd_a); end
    held = bcd_a;
    iv[0] = 1'b1; bin_a = 10'd5;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || bcd_a !== held || ir[0] !== 1'b0
          || lz_a !== 3'b000 || ovf[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold c=%0d got=%b/%h/%b exp=1/%h/0",
                 c, ov[0], bcd_a, ir[0], held);
      end
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin failures++;
      $display("FAIL bp_release got=%b/%b exp=0/1", ov[0], ir[0]); end
  endtask

  task automatic test_back_to_back();
    int t, nres;
    int tv[2] = '{-1, -1};
    logic [11:0] rv[2] = '{12'h0, 12'h0};
    logic rdy0 = 1'b0;
    @(negedge clk);
    bin_a = 10'd123; iv[0] = 1'b1; ordy[0] = 1'b1;
    nres = 0;
    @(posedge clk);
    t = 1;
    @(negedge clk);
    bin_a = 10'd456;
    while (nres < 2 && t < 80) begin
      if (ov[0]) begin
        tv[nres] = t; rv[nres] = bcd_a;
        if (nres == 0) rdy0 = ir[0];
        nres++;
      end else if (nres == 1) iv[0] = 1'b0;
      @(negedge clk);
      t++;
    end
    iv[0] = 1'b0; ordy[0] = 1'b0;
    checks++;
    if (nres !== 2) begin failures++;
      $display("FAIL b2b_count got=%0d exp=2", nres); end
    checks++;
    if (tv[0] !== 11) begin failures++;
      $display("FAIL b2b_first_time got=%0d exp=11", tv[0]); end
    checks++;
    if (tv[1] - tv[0] !== 11) begin failures++;
      $display("FAIL b2b_spacing got=%0d exp=11", tv[1] - tv[0]); end
    checks++;
    if (rv[0] !== 12'h123 || rv[1] !== 12'h456) begin failures++;
      $display("FAIL b2b_values got=%h,%h exp=123,456", rv[0], rv[1]); end
    checks++;
    if (rdy0 !== 1'b1) begin failures++;
      $display("FAIL b2b_in_ready got=%b exp=1", rdy0); end
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    @(negedge clk);
    bin_a = 10'd777; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bcd_a !== 12'h000) begin
      failures++;
      $display("FAIL abort_reset got=%b/%b/%h exp=0/1/000",
               ov[0], ir[0], bcd_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || ir[0] !== 1'b1) begin failures++;
      $display("FAIL abort_no_partial got=%b/%b exp=0/1", seen, ir[0]); end
    check_conv(0, 3, 10, 88, 1'b1);
  endtask

  task automatic test_wide();
    check_conv(1, 5, 14, 16383, 1'b1);
    check_conv(1, 5, 14, 0, 1'b1);
    for (int i = 0; i < 8; i++)
      check_conv(1, 5, 14, $urandom_range(16383, 0), 1'b0);
  endtask

  task automatic test_narrow();
    for (int v = 0; v < 16; v++)
      check_conv(2, 1, 4, v, v == 9);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    test_narrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
